// File: rtl/axis_pkt_rr_arbiter.sv
// axis_pkt_rr_arbiter: packet-level round-robin arbiter in front of a shared
// AXIS datapath. One whole packet (first beat through tlast) is passed per
// grant, then the pointer rotates past the granted port. Packets longer than
// MAX_BEATS are cut with a forced tlast and the remainder is discarded.
// Optional per-port statistics: define AXIS_PKT_RR_ARBITER_STATS_EN.
module axis_pkt_rr_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_BYTES = 8,
    parameter int MAX_BEATS  = 256,
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int DW    = DATA_BYTES * 8
) (
    input  logic                             clk,
    input  logic                             sreset,
    input  logic [NUM_PORTS-1:0]             in_tvalid,
    output logic [NUM_PORTS-1:0]             in_tready,
    input  logic [NUM_PORTS*DW-1:0]          in_tdata,
    input  logic [NUM_PORTS*DATA_BYTES-1:0]  in_tkeep,
    input  logic [NUM_PORTS-1:0]             in_tlast,
    output logic                             out_tvalid,
    input  logic                             out_tready,
    output logic [DW-1:0]                    out_tdata,
    output logic [DATA_BYTES-1:0]            out_tkeep,
    output logic                             out_tlast,
    output logic                             grant_valid,
    output logic [IDX_W-1:0]                 grant_idx,
    output logic                             oversize,
    output logic [IDX_W-1:0]                 oversize_port
`ifdef AXIS_PKT_RR_ARBITER_STATS_EN
    ,
    output logic [NUM_PORTS*32-1:0]          pkt_count,
    output logic [NUM_PORTS*32-1:0]          drop_beats,
    input  logic                             stats_clear
`endif
);

    generate
        if (NUM_PORTS < 1 || NUM_PORTS > 16) begin : g_bad_num_ports
            $error("axis_pkt_rr_arbiter: NUM_PORTS must be in 1..16");
        end
        if (MAX_BEATS < 2 || MAX_BEATS > 65535) begin : g_bad_max_beats
            $error("axis_pkt_rr_arbiter: MAX_BEATS must be in 2..65535");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, PASS, FLUSH} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [15:0]      beat_cnt_q, beat_cnt_d;
    logic             oversize_q, oversize_d;
    logic [IDX_W-1:0] ovp_q, ovp_d;

    // Per-port views of the flat source buses.
    logic [NUM_PORTS-1:0][DW-1:0]         tdata_a;
    logic [NUM_PORTS-1:0][DATA_BYTES-1:0] tkeep_a;
    assign tdata_a = in_tdata;
    assign tkeep_a = in_tkeep;

    logic [2*NUM_PORTS-1:0] req_rot;
    logic [IDX_W-1:0]       pick_off;
    logic [IDX_W:0]         pick_sum;
    logic [IDX_W-1:0]       pick;
    logic [IDX_W-1:0]       next_rr;
    logic                   at_max;

    assign at_max  = (beat_cnt_q == 16'(MAX_BEATS - 1));
    // Pointer moves one past the port that just finished; constant 0 for one port.
    assign next_rr = (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;

    // Round-robin pick: rotate requests so rr_ptr lands at bit 0, take the lowest set bit.
    always_comb begin
        req_rot  = {in_tvalid, in_tvalid} >> rr_ptr_q;
        pick_off = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (req_rot[k]) pick_off = IDX_W'(k);
        end
        pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
        if (pick_sum >= (IDX_W + 1)'(NUM_PORTS)) pick_sum = pick_sum - (IDX_W + 1)'(NUM_PORTS);
        pick = pick_sum[IDX_W-1:0];
    end

    // Next-state and combinational datapath steering for IDLE/PASS/FLUSH.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        oversize_d = 1'b0;
        ovp_d      = ovp_q;
        in_tready  = '0;
        out_tvalid = 1'b0;
        out_tdata  = tdata_a[grant_q];
        out_tkeep  = tkeep_a[grant_q];
        out_tlast  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|in_tvalid) begin
                    grant_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = PASS;
                end
            end
            PASS: begin
                out_tvalid         = in_tvalid[grant_q];
                in_tready[grant_q] = out_tready;
                // The last allowed beat always closes the packet downstream.
                out_tlast          = in_tlast[grant_q] | at_max;
                if (out_tvalid && out_tready) begin
                    beat_cnt_d = beat_cnt_q + 16'd1;
                    if (in_tlast[grant_q]) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_rr;
                    end else if (at_max) begin
                        oversize_d = 1'b1;
                        ovp_d      = grant_q;
                        state_d    = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // Drain the rest of the runaway packet; nothing reaches the output.
                in_tready[grant_q] = 1'b1;
                if (in_tvalid[grant_q] && in_tlast[grant_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_rr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            oversize_q <= 1'b0;
            ovp_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            oversize_q <= oversize_d;
            ovp_q      <= ovp_d;
        end
    end

    assign grant_valid   = (state_q != IDLE);
    assign grant_idx     = grant_q;
    assign oversize      = oversize_q;
    assign oversize_port = ovp_q;

`ifdef AXIS_PKT_RR_ARBITER_STATS_EN
    logic [NUM_PORTS-1:0][31:0] pkt_cnt_q, pkt_cnt_d;
    logic [NUM_PORTS-1:0][31:0] drop_cnt_q, drop_cnt_d;

    // Packet completions (natural or forced tlast) and flushed beats per port; clear wins.
    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (stats_clear) begin
            pkt_cnt_d  = '0;
            drop_cnt_d = '0;
        end else begin
            if (state_q == PASS && out_tvalid && out_tready && out_tlast)
                pkt_cnt_d[grant_q] = pkt_cnt_q[grant_q] + 32'd1;
            if (state_q == FLUSH && in_tvalid[grant_q])
                drop_cnt_d[grant_q] = drop_cnt_q[grant_q] + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (sreset) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pkt_count  = pkt_cnt_q;
    assign drop_beats = drop_cnt_q;
`endif

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Directed bench for axis_pkt_rr_arbiter. Two instances share the source
// buses: dut (MAX_BEATS=4) for arbitration/oversize scenarios and dut_big
// (MAX_BEATS=8) for a 5-beat packet under a toggling out_tready.
module tb_axis_pkt_rr_arbiter;
    localparam int NP = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            sreset = 1'b1;
    logic [NP-1:0]   in_tvalid = '0;
    logic [NP*64-1:0] in_tdata = '0;
    logic [NP*8-1:0] in_tkeep = '0;
    logic [NP-1:0]   in_tlast = '0;
    logic            out_tready = 1'b1;

    logic [NP-1:0] s_in_tready, b_in_tready;
    logic          s_out_tvalid, b_out_tvalid;
    logic [63:0]   s_out_tdata, b_out_tdata;
    logic [7:0]    s_out_tkeep, b_out_tkeep;
    logic          s_out_tlast, b_out_tlast;
    logic          s_gv, b_gv;
    logic [1:0]    s_gi, b_gi;
    logic          s_ov, b_ov;
    logic [1:0]    s_ovp, b_ovp;

    axis_pkt_rr_arbiter #(.NUM_PORTS(NP), .DATA_BYTES(8), .MAX_BEATS(4)) dut (
        .clk(clk), .sreset(sreset),
        .in_tvalid(in_tvalid), .in_tready(s_in_tready), .in_tdata(in_tdata),
        .in_tkeep(in_tkeep), .in_tlast(in_tlast),
        .out_tvalid(s_out_tvalid), .out_tready(out_tready), .out_tdata(s_out_tdata),
        .out_tkeep(s_out_tkeep), .out_tlast(s_out_tlast),
        .grant_valid(s_gv), .grant_idx(s_gi), .oversize(s_ov), .oversize_port(s_ovp)
    );

    axis_pkt_rr_arbiter #(.NUM_PORTS(NP), .DATA_BYTES(8), .MAX_BEATS(8)) dut_big (
        .clk(clk), .sreset(sreset),
        .in_tvalid(in_tvalid), .in_tready(b_in_tready), .in_tdata(in_tdata),
        .in_tkeep(in_tkeep), .in_tlast(in_tlast),
        .out_tvalid(b_out_tvalid), .out_tready(out_tready), .out_tdata(b_out_tdata),
        .out_tkeep(b_out_tkeep), .out_tlast(b_out_tlast),
        .grant_valid(b_gv), .grant_idx(b_gi), .oversize(b_ov), .oversize_port(b_ovp)
    );

    int n_chk = 0;
    int n_bad = 0;
    bit use_big = 1'b0;

    // Source queues: {last, keep[7:0], data[63:0]}
    logic [72:0] srcq [NP][$];
    logic [NP-1:0] fired = '0;

    // Per-cycle observations of the selected instance
    logic [NP-1:0] cur_rdy;
    logic cur_otv, cur_otl, cur_gv, cur_ov;
    logic [63:0] cur_otd;
    logic [7:0]  cur_otk;
    logic [1:0]  cur_gi, cur_ovp;

    bit   gv_log[$];
    int   gi_log[$];
    bit   ov_log[$];
    int   ovp_log[$];
    bit   otv_log[$];
    logic [NP-1:0] rdy_log[$];
    logic [72:0] outq[$];

    function automatic logic [72:0] mkbeat(int p, int b, bit last, logic [7:0] keep);
        logic [63:0] d;
        d = 64'hA5A5_0000_0000_0000 | (64'(p) << 16) | 64'(b);
        return {last, keep, d};
    endfunction

    task automatic push_pkt(input int p, input int n);
        for (int b = 0; b < n; b++)
            srcq[p].push_back(mkbeat(p, b, b == n - 1, (b == n - 1) ? 8'h0F : 8'hFF));
    endtask

    // One clock: retire last cycle's handshakes, drive sources, observe outputs.
    task automatic step(input logic rdy, input logic rst);
        @(negedge clk);
        for (int p = 0; p < NP; p++)
            if (fired[p] && srcq[p].size() > 0) void'(srcq[p].pop_front());
        for (int p = 0; p < NP; p++) begin
            if (srcq[p].size() > 0) begin
                in_tvalid[p] = 1'b1;
                {in_tlast[p], in_tkeep[p*8 +: 8], in_tdata[p*64 +: 64]} = srcq[p][0];
            end else begin
                in_tvalid[p] = 1'b0;
                {in_tlast[p], in_tkeep[p*8 +: 8], in_tdata[p*64 +: 64]} = '0;
            end
        end
        out_tready = rdy;
        sreset     = rst;
        #1;
        if (use_big) begin
            cur_rdy = b_in_tready; cur_otv = b_out_tvalid; cur_otd = b_out_tdata;
            cur_otk = b_out_tkeep; cur_otl = b_out_tlast; cur_gv = b_gv;
            cur_gi = b_gi; cur_ov = b_ov; cur_ovp = b_ovp;
        end else begin
            cur_rdy = s_in_tready; cur_otv = s_out_tvalid; cur_otd = s_out_tdata;
            cur_otk = s_out_tkeep; cur_otl = s_out_tlast; cur_gv = s_gv;
            cur_gi = s_gi; cur_ov = s_ov; cur_ovp = s_ovp;
        end
        fired = in_tvalid & cur_rdy;
        gv_log.push_back(cur_gv);
        gi_log.push_back(int'(cur_gi));
        ov_log.push_back(cur_ov);
        ovp_log.push_back(int'(cur_ovp));
        otv_log.push_back(cur_otv);
        rdy_log.push_back(cur_rdy);
        if (cur_otv && rdy) outq.push_back({cur_otl, cur_otk, cur_otd});
    endtask

    task automatic do_reset();
        for (int p = 0; p < NP; p++) srcq[p].delete();
        fired = '0;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        gv_log.delete(); gi_log.delete(); ov_log.delete(); ovp_log.delete();
        otv_log.delete(); rdy_log.delete(); outq.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (cur_gv !== 1'b0) begin n_bad++; $display("FAIL reset_gv got=%0b exp=0", cur_gv); end
        n_chk++; if (cur_gi !== 2'd0) begin n_bad++; $display("FAIL reset_gi got=%0d exp=0", cur_gi); end
        n_chk++; if (cur_ov !== 1'b0 || cur_ovp !== 2'd0) begin n_bad++; $display("FAIL reset_ov got=%0b/%0d exp=0/0", cur_ov, cur_ovp); end
        n_chk++; if (cur_rdy !== 4'b0 || cur_otv !== 1'b0) begin n_bad++; $display("FAIL reset_hs got rdy=%b otv=%0b exp=0000/0", cur_rdy, cur_otv); end
    endtask

    task automatic test_two_ports();
        bit exp_gv [14] = '{0,1,1,1,0,1,1,1,0,0,1,0,1,0};
        int exp_gi [14] = '{0,0,0,0,0,2,2,2,0,0,3,0,0,0};
        logic [72:0] exp_q[$];
        do_reset();
        push_pkt(0, 3);
        push_pkt(2, 3);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
        // pointer now sits at 3: port 3 must beat port 0
        push_pkt(0, 1);
        push_pkt(3, 1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 14; i++) begin
            n_chk++;
            if (gv_log[i] !== exp_gv[i]) begin n_bad++; $display("FAIL two_ports_gv[%0d] got=%0b exp=%0b", i, gv_log[i], exp_gv[i]); end
            if (exp_gv[i]) begin
                n_chk++;
                if (gi_log[i] !== exp_gi[i]) begin n_bad++; $display("FAIL two_ports_gi[%0d] got=%0d exp=%0d", i, gi_log[i], exp_gi[i]); end
            end
        end
        n_chk++; if (otv_log[4] !== 1'b0) begin n_bad++; $display("FAIL two_ports_idle_otv got=%0b exp=0", otv_log[4]); end
        for (int b = 0; b < 3; b++) exp_q.push_back(mkbeat(0, b, b == 2, (b == 2) ? 8'h0F : 8'hFF));
        for (int b = 0; b < 3; b++) exp_q.push_back(mkbeat(2, b, b == 2, (b == 2) ? 8'h0F : 8'hFF));
        exp_q.push_back(mkbeat(3, 0, 1'b1, 8'h0F));
        exp_q.push_back(mkbeat(0, 0, 1'b1, 8'h0F));
        n_chk++; if (outq.size() != exp_q.size()) begin n_bad++; $display("FAIL two_ports_nbeats got=%0d exp=%0d", outq.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < outq.size(); i++) begin
            n_chk++;
            if (outq[i] !== exp_q[i]) begin n_bad++; $display("FAIL two_ports_beat[%0d] got=%h exp=%h", i, outq[i], exp_q[i]); end
        end
    endtask

    task automatic test_round_robin();
        int exp_gi [6] = '{0,1,2,3,0,1};
        do_reset();
        for (int p = 0; p < NP; p++) for (int k = 0; k < 3; k++) push_pkt(p, 1);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
        for (int j = 0; j < 6; j++) begin
            n_chk++;
            if (gv_log[2*j+1] !== 1'b1 || gi_log[2*j+1] !== exp_gi[j]) begin
                n_bad++; $display("FAIL rr_grant[%0d] got=%0b/%0d exp=1/%0d", j, gv_log[2*j+1], gi_log[2*j+1], exp_gi[j]);
            end
        end
        n_chk++; if (outq.size() != 6) begin n_bad++; $display("FAIL rr_nbeats got=%0d exp=6", outq.size()); end
        for (int j = 0; j < 6 && j < outq.size(); j++) begin
            n_chk++;
            if (outq[j] !== mkbeat(exp_gi[j], 0, 1'b1, 8'h0F)) begin n_bad++; $display("FAIL rr_beat[%0d] got=%h", j, outq[j]); end
        end
    endtask

    task automatic test_oversize();
        logic [72:0] exp_q[$];
        do_reset();
        push_pkt(1, 6);
        push_pkt(2, 1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            n_chk++;
            if (ov_log[i] !== (i == 5)) begin n_bad++; $display("FAIL ovs_pulse[%0d] got=%0b exp=%0b", i, ov_log[i], i == 5); end
        end
        n_chk++; if (ovp_log[5] !== 1 || ovp_log[9] !== 1) begin n_bad++; $display("FAIL ovs_port got=%0d/%0d exp=1/1", ovp_log[5], ovp_log[9]); end
        for (int i = 5; i <= 6; i++) begin
            n_chk++;
            if (otv_log[i] !== 1'b0 || rdy_log[i] !== 4'b0010 || gv_log[i] !== 1'b1) begin
                n_bad++; $display("FAIL ovs_flush[%0d] got otv=%0b rdy=%b gv=%0b exp=0/0010/1", i, otv_log[i], rdy_log[i], gv_log[i]);
            end
        end
        n_chk++; if (gi_log[8] !== 2 || gv_log[8] !== 1'b1) begin n_bad++; $display("FAIL ovs_next_grant got=%0d exp=2", gi_log[8]); end
        for (int b = 0; b < 4; b++) exp_q.push_back(mkbeat(1, b, b == 3, 8'hFF));
        exp_q.push_back(mkbeat(2, 0, 1'b1, 8'h0F));
        n_chk++; if (outq.size() != exp_q.size()) begin n_bad++; $display("FAIL ovs_nbeats got=%0d exp=%0d", outq.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < outq.size(); i++) begin
            n_chk++;
            if (outq[i] !== exp_q[i]) begin n_bad++; $display("FAIL ovs_beat[%0d] got=%h exp=%h", i, outq[i], exp_q[i]); end
        end
    endtask

    task automatic test_exact_max();
        logic [72:0] exp_q[$];
        do_reset();
        push_pkt(1, 4);
        push_pkt(2, 1);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            n_chk++;
            if (ov_log[i] !== 1'b0 || ovp_log[i] !== 0) begin n_bad++; $display("FAIL exact_ov[%0d] got=%0b/%0d exp=0/0", i, ov_log[i], ovp_log[i]); end
        end
        n_chk++; if (gv_log[5] !== 1'b0 || gi_log[6] !== 2) begin n_bad++; $display("FAIL exact_rotate got gv5=%0b gi6=%0d exp=0/2", gv_log[5], gi_log[6]); end
        for (int b = 0; b < 4; b++) exp_q.push_back(mkbeat(1, b, b == 3, (b == 3) ? 8'h0F : 8'hFF));
        exp_q.push_back(mkbeat(2, 0, 1'b1, 8'h0F));
        n_chk++; if (outq.size() != exp_q.size()) begin n_bad++; $display("FAIL exact_nbeats got=%0d exp=%0d", outq.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < outq.size(); i++) begin
            n_chk++;
            if (outq[i] !== exp_q[i]) begin n_bad++; $display("FAIL exact_beat[%0d] got=%h exp=%h", i, outq[i], exp_q[i]); end
        end
    endtask

    task automatic test_tready_toggle();
        use_big = 1'b1;
        do_reset();
        push_pkt(3, 5);
        step(1'b1, 1'b0);
        // competing sources appear once port 3 already holds the grant
        push_pkt(0, 2);
        push_pkt(1, 2);
        for (int i = 1; i <= 9; i++) step(logic'(i % 2), 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            n_chk++;
            if (rdy_log[i] !== {logic'(i % 2), 3'b000} || otv_log[i] !== 1'b1 || gi_log[i] !== 3) begin
                n_bad++; $display("FAIL toggle_hs[%0d] got rdy=%b otv=%0b gi=%0d exp=%b/1/3", i, rdy_log[i], otv_log[i], gi_log[i], {logic'(i % 2), 3'b000});
            end
        end
        n_chk++; if (outq.size() < 5) begin n_bad++; $display("FAIL toggle_nbeats got=%0d exp>=5", outq.size()); end
        for (int b = 0; b < 5 && b < outq.size(); b++) begin
            n_chk++;
            if (outq[b] !== mkbeat(3, b, b == 4, (b == 4) ? 8'h0F : 8'hFF)) begin n_bad++; $display("FAIL toggle_beat[%0d] got=%h", b, outq[b]); end
        end
        n_chk++; if (gv_log[10] !== 1'b0 || gi_log[11] !== 0) begin n_bad++; $display("FAIL toggle_next got gv10=%0b gi11=%0d exp=0/0", gv_log[10], gi_log[11]); end
        use_big = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_pkt(0, 3);
        push_pkt(1, 2);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        n_chk++;
        if (gv_log[3] !== 1'b0 || gi_log[3] !== 0 || otv_log[3] !== 1'b0 || rdy_log[3] !== 4'b0 || ov_log[3] !== 1'b0 || ovp_log[3] !== 0) begin
            n_bad++; $display("FAIL rstmid_outputs got gv=%0b gi=%0d otv=%0b rdy=%b ov=%0b exp=0/0/0/0000/0", gv_log[3], gi_log[3], otv_log[3], rdy_log[3], ov_log[3]);
        end
        n_chk++; if (gv_log[4] !== 1'b1 || gi_log[4] !== 0) begin n_bad++; $display("FAIL rstmid_regrant got=%0b/%0d exp=1/0", gv_log[4], gi_log[4]); end
        n_chk++;
        if (outq.size() != 3 || outq[outq.size()-1] !== mkbeat(0, 2, 1'b1, 8'h0F)) begin
            n_bad++; $display("FAIL rstmid_beats got n=%0d exp n=3 ending with port0 beat2", outq.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_two_ports();
        test_round_robin();
        test_oversize();
        test_exact_max();
        test_tready_toggle();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
